weight_fetch_sequencer: RTL
===========================

// Module: weight_fetch_sequencer
// PURPOSE
//  Sequences one weight-tile fetch for the WinoCNN weight path. On a main-controller prepare,
//  issues 18 bank addresses (lanes 0-8 = kernel of od1, lanes 9-17 = kernel of od2, input channel id)
//  and collects the returned words. Then reports ready and streams the tile to the PE array for a
//  configured number of reuse beats. Sits between the main controller, weight memory and PE arrays.
// PARAMETERS
//  LANES    18  memory lanes (2 output channels x KSIZE)
//  KSIZE    9   weights per 3x3 kernel
//  ADDR_W   16  memory address width
//  DATA_W   16  weight word width
//  TMO_CYC  64  WAIT watchdog limit, cycles (used only with WEIGHT_TMO_EN)
// PORTS
//  clk               in   1             clock
//  reset             in   1             synchronous, active-high
//  cfg_wen_i         in   1             latch cfg_* this cycle
//  cfg_total_id_i    in   8             input-channel count
//  cfg_total_od_i    in   8             output-channel count
//  cfg_size_type_i   in   1             0 = 3x3 kernel, 1 = 1x1 kernel
//  cfg_reuse_i       in   8             PE beats per tile (0 treated as 1)
//  weight_prepare_i  in   1             fetch request, 1-cycle pulse
//  weight_od1_i      in   8             first output channel
//  weight_od2_i      in   8             second output channel
//  weight_id_i       in   8             input channel
//  weight_start_i    in   1             begin streaming, 1-cycle pulse
//  weight_ready_o    out  1             tile buffered, awaiting start
//  busy_o            out  1             state != IDLE
//  err_range_o       out  1             sticky: od/id out of range on prepare
//  err_tmo_o         out  1             sticky: watchdog fired (WEIGHT_TMO_EN only, else 0)
//  mem_req_o         out  1             addresses valid, 1-cycle pulse
//  mem_addr_o        out  LANES*ADDR_W  lane k at [k*ADDR_W +: ADDR_W]
//  mem_valid_i       in   LANES         per-lane return strobe
//  mem_addr_i        in   LANES*ADDR_W  returned address per lane
//  mem_data_i        in   LANES*DATA_W  returned data per lane
//  pe_valid_o        out  1             pe_weight_o valid
//  pe_ready_i        in   1             PE accepts beat
//  pe_weight_o       out  LANES*DATA_W  buffered tile
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cfg regs 0, lane mask 0, buffer 0. Reset mid-op aborts instantly.
//  Config: cfg_* latched on cfg_wen_i in any state; a fetch in flight uses values latched at prepare.
//  FSM IDLE->ISSUE->WAIT->READY->STREAM->IDLE.
//  IDLE: prepare_i with od1,od2<total_od and id<total_id -> latch indices, go ISSUE.
//    Out of range -> set err_range_o, stay IDLE. prepare_i in any other state is ignored.
//  ISSUE: one cycle with mem_req_o=1 and mem_addr_o driven; lane mask reset to the enabled lanes; go WAIT.
//    Lane k (j = k mod KSIZE, od = k<KSIZE ? od1 : od2):
//    3x3: addr = (od*total_id + id)*9 + j.
//    1x1: only lanes 0 and 9 enabled, addr = od*total_id + id. Disabled lanes drive addr 0 and are pre-marked done.
//    Arithmetic is unsigned, computed >=24 bits, truncated mod 2^ADDR_W.
//  mem_addr_o holds the issued addresses until the next ISSUE.
//  WAIT: a lane return counts only if mem_valid_i[k], lane k still pending, and mem_addr_i[k]==issued addr[k].
//    Counted return -> data captured into buffer lane k, lane marked done.
//    Duplicate or mismatched returns are ignored. Several lanes may return in one cycle.
//    All enabled lanes done -> READY next cycle. Disabled lanes' buffer entries are 0.
//  READY: weight_ready_o=1. start_i -> STREAM. start_i outside READY is ignored.
//  STREAM: pe_valid_o=1, pe_weight_o=buffer. Beat count increments on pe_valid_o&&pe_ready_i.
//    After max(cfg_reuse,1) beats -> IDLE; pe_valid_o falls the cycle after the last beat.
//  Latency: prepare edge to mem_req_o = 1 cycle. Last lane return to weight_ready_o = 1 cycle.
// CONFIGURATION
//  WEIGHT_TMO_EN defined: a WAIT cycle counter counts from WAIT entry.
//    Reaching TMO_CYC with lanes still pending -> err_tmo_o set (sticky until reset), FSM -> IDLE, buffer untouched.
//  WEIGHT_TMO_EN undefined: no counter; WAIT waits indefinitely; err_tmo_o tied 0.
// TESTING
//  cfg id=4,od=8,3x3; prepare od1=1,od2=2,id=3. Required lane addrs: lanes 0-8 = 63..71, lanes 9-17 = 99..107.
//    Memory returns all lanes after 3 cycles -> weight_ready_o 1 cycle later.
//  Same fetch with 1x1: only lanes 0/9 pending, addrs 7 and 11. Returns complete the tile; other lanes read 0.
//  Out-of-order returns with one wrong-addr strobe and one duplicate on lane 5.
//    -> tile completes only on a correct lane-5 strobe; data equals correct values.
//  reuse=3, pe_ready_i 1,0,1,1 -> exactly 3 accepted beats, then IDLE. prepare/start during STREAM ignored.
//  prepare od1=8 with total_od=8 -> err_range_o=1, no mem_req_o. Reset during WAIT -> all outputs 0 next cycle.
//  WEIGHT_TMO_EN, lane 17 never returns -> err_tmo_o=1 after TMO_CYC=64 WAIT cycles, FSM in IDLE.

Source files
------------

// File: rtl/weight_fetch_sequencer.sv
// Weight-tile fetch sequencer: issues 18 lane addresses, collects matching returns, streams tile to PEs.
// Optional WAIT watchdog enabled by defining WEIGHT_TMO_EN.
module weight_fetch_sequencer #(
    parameter int LANES   = 18,
    parameter int KSIZE   = 9,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_wen_i,
    input  logic [7:0]                cfg_total_id_i,
    input  logic [7:0]                cfg_total_od_i,
    input  logic                      cfg_size_type_i,
    input  logic [7:0]                cfg_reuse_i,
    input  logic                      weight_prepare_i,
    input  logic [7:0]                weight_od1_i,
    input  logic [7:0]                weight_od2_i,
    input  logic [7:0]                weight_id_i,
    input  logic                      weight_start_i,
    output logic                      weight_ready_o,
    output logic                      busy_o,
    output logic                      err_range_o,
    output logic                      err_tmo_o,
    output logic                      mem_req_o,
    output logic [LANES*ADDR_W-1:0]   mem_addr_o,
    input  logic [LANES-1:0]          mem_valid_i,
    input  logic [LANES*ADDR_W-1:0]   mem_addr_i,
    input  logic [LANES*DATA_W-1:0]   mem_data_i,
    output logic                      pe_valid_o,
    input  logic                      pe_ready_i,
    output logic [LANES*DATA_W-1:0]   pe_weight_o
);

    // state    | meaning
    // IDLE     | waiting for prepare
    // ISSUE    | mem_req_o pulse, pending mask loaded
    // WAIT     | collecting lane returns
    // READY    | tile buffered, waiting for start
    // STREAM   | presenting tile to PE array for reuse beats
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_READY,
        ST_STREAM
    } state_t;

    state_t                    state_q;
    logic [7:0]                total_id_q;
    logic [7:0]                total_od_q;
    logic                      size_type_q;
    logic [7:0]                reuse_q;
    logic [7:0]                f_reuse_q;
    logic [LANES*ADDR_W-1:0]   addr_q;
    logic [LANES-1:0]          en_q;
    logic [LANES-1:0]          pend_q;
    logic [LANES*DATA_W-1:0]   buf_q;
    logic [7:0]                beat_q;
    logic                      mem_req_q;
    logic                      ready_q;
    logic                      pe_valid_q;
    logic                      err_range_q;

    logic                      in_range_w;
    logic [23:0]               base1_w;
    logic [23:0]               base2_w;
    logic [LANES*ADDR_W-1:0]   addr_d;
    logic [LANES-1:0]          en_d;
    logic [LANES-1:0]          hit_w;
    logic [LANES-1:0]          pend_d;
    logic [7:0]                reuse_eff_w;
    logic                      last_beat_w;

    assign in_range_w = (weight_od1_i < total_od_q) && (weight_od2_i < total_od_q)
                        && (weight_id_i < total_id_q);

    // Addresses use the cfg already latched; a same-cycle cfg write applies to the next fetch.
    always_comb begin
        logic [23:0] lane_base;
        logic [23:0] lane_addr;
        base1_w = 24'(weight_od1_i) * 24'(total_id_q) + 24'(weight_id_i);
        base2_w = 24'(weight_od2_i) * 24'(total_id_q) + 24'(weight_id_i);
        addr_d  = '0;
        en_d    = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_base = (k < KSIZE) ? base1_w : base2_w;
            if (size_type_q) begin
                lane_addr = lane_base;
                en_d[k]   = (k == 0) || (k == KSIZE);
            end else begin
                lane_addr = lane_base * 24'(KSIZE) + 24'(k % KSIZE);
                en_d[k]   = 1'b1;
            end
            addr_d[k*ADDR_W +: ADDR_W] = en_d[k] ? ADDR_W'(lane_addr) : '0;
        end
    end

    always_comb begin
        hit_w = '0;
        for (int k = 0; k < LANES; k++) begin
            hit_w[k] = mem_valid_i[k] && pend_q[k]
                       && (mem_addr_i[k*ADDR_W +: ADDR_W] == addr_q[k*ADDR_W +: ADDR_W]);
        end
        pend_d = pend_q & ~hit_w;
    end

    assign reuse_eff_w = (f_reuse_q == 8'd0) ? 8'd1 : f_reuse_q;
    assign last_beat_w = (beat_q == reuse_eff_w - 8'd1);

`ifdef WEIGHT_TMO_EN
    localparam int TW = $clog2(TMO_CYC) + 1;
    logic [TW-1:0] wcnt_q;
    logic          err_tmo_q;
    assign err_tmo_o = err_tmo_q;
`else
    logic unused_tmo_w;
    assign unused_tmo_w = |TMO_CYC;
    assign err_tmo_o    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            total_id_q  <= '0;
            total_od_q  <= '0;
            size_type_q <= 1'b0;
            reuse_q     <= '0;
            f_reuse_q   <= '0;
            addr_q      <= '0;
            en_q        <= '0;
            pend_q      <= '0;
            buf_q       <= '0;
            beat_q      <= '0;
            mem_req_q   <= 1'b0;
            ready_q     <= 1'b0;
            pe_valid_q  <= 1'b0;
            err_range_q <= 1'b0;
`ifdef WEIGHT_TMO_EN
            wcnt_q      <= '0;
            err_tmo_q   <= 1'b0;
`endif
        end else begin
            mem_req_q <= 1'b0;
            if (cfg_wen_i) begin
                total_id_q  <= cfg_total_id_i;
                total_od_q  <= cfg_total_od_i;
                size_type_q <= cfg_size_type_i;
                reuse_q     <= cfg_reuse_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (weight_prepare_i) begin
                        if (in_range_w) begin
                            state_q   <= ST_ISSUE;
                            mem_req_q <= 1'b1;
                            addr_q    <= addr_d;
                            en_q      <= en_d;
                            f_reuse_q <= reuse_q;
                        end else begin
                            err_range_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    pend_q  <= en_q;
                    buf_q   <= '0;
                    state_q <= ST_WAIT;
`ifdef WEIGHT_TMO_EN
                    wcnt_q  <= '0;
`endif
                end
                ST_WAIT: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (hit_w[k]) begin
                            buf_q[k*DATA_W +: DATA_W] <= mem_data_i[k*DATA_W +: DATA_W];
                        end
                    end
                    pend_q <= pend_d;
                    if (pend_d == '0) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
`ifdef WEIGHT_TMO_EN
                    else if (wcnt_q == TW'(TMO_CYC - 1)) begin
                        err_tmo_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
`endif
                end
                ST_READY: begin
                    if (weight_start_i) begin
                        state_q    <= ST_STREAM;
                        ready_q    <= 1'b0;
                        pe_valid_q <= 1'b1;
                        beat_q     <= '0;
                    end
                end
                ST_STREAM: begin
                    if (pe_valid_q && pe_ready_i) begin
                        if (last_beat_w) begin
                            state_q    <= ST_IDLE;
                            pe_valid_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign weight_ready_o = ready_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign err_range_o    = err_range_q;
    assign mem_req_o      = mem_req_q;
    assign mem_addr_o     = addr_q;
    assign pe_valid_o     = pe_valid_q;
    assign pe_weight_o    = pe_valid_q ? buf_q : '0;

endmodule
